// File: rtl/rv_mdu_pkg.sv
// Shared definitions for the rv_mdu_iter iterative RV32M/RV64M multiply/divide unit.
package rv_mdu_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  // Width of a counter that must hold the values 0 .. n-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rv_mdu_step.sv
// One combinational iteration of the MDU datapath: BPC shift-add (multiply) or
// restore-subtract (divide) steps. Divide packs {remainder, dividend/quotient} into acc.
module rv_mdu_step #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic              div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [2*XLEN-1:0] opd_i,
  input  logic [XLEN-1:0]   mplr_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic [2*XLEN-1:0] opd_o,
  output logic [XLEN-1:0]   mplr_o
);

  logic [2*XLEN-1:0] acc_v;
  logic [2*XLEN-1:0] opd_v;
  logic [XLEN-1:0]   mplr_v;
  logic [XLEN:0]     tmp_v;
  logic [XLEN+1:0]   diff_v;

  // Unrolled BPC iterations of the selected algorithm
  always_comb begin
    acc_v  = acc_i;
    opd_v  = opd_i;
    mplr_v = mplr_i;
    tmp_v  = '0;
    diff_v = '0;
    for (int i = 0; i < BPC; i++) begin
      if (div_i) begin
        tmp_v  = {acc_v[2*XLEN-1:XLEN], acc_v[XLEN-1]};
        diff_v = {1'b0, tmp_v} - {2'b00, opd_v[XLEN-1:0]};
        if (!diff_v[XLEN+1]) begin
          acc_v = {diff_v[XLEN-1:0], acc_v[XLEN-2:0], 1'b1};
        end else begin
          acc_v = {tmp_v[XLEN-1:0], acc_v[XLEN-2:0], 1'b0};
        end
      end else begin
        if (mplr_v[0]) begin
          acc_v = acc_v + opd_v;
        end else begin
          acc_v = acc_v;
        end
        opd_v  = opd_v << 1'b1;
        mplr_v = mplr_v >> 1'b1;
      end
    end
  end

  assign acc_o  = acc_v;
  assign opd_o  = opd_v;
  assign mplr_o = mplr_v;

endmodule

// File: rtl/rv_mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit with START/BUSY/DONE handshake and FLUSH.
// Optional multiply early-out when the macro RV_MDU_EARLY_OUT_EN is defined.
module rv_mdu_iter
  import rv_mdu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [2:0]      FUNC3,
  input  logic [XLEN-1:0] OP_A,
  input  logic [XLEN-1:0] OP_B,
  input  logic [4:0]      RD_IN,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT,
  output logic [4:0]      RD_OUT
);

  localparam int              N     = XLEN / BITS_PER_CYCLE;
  localparam int              CW    = cnt_width(N);
  localparam logic [CW-1:0]   LAST  = CW'(N - 1);
  localparam logic [XLEN-1:0] X_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] opd_q, opd_d;
  logic [XLEN-1:0]   mplr_q, mplr_d;
  logic [2:0]        func_q, func_d;
  logic              neg_q, neg_d;
  logic [4:0]        rd_tag_q, rd_tag_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              is_div_s, a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s;
  logic              div_zero_s, ovf_s, special_s;
  logic [XLEN-1:0]   special_res_s;
  logic [2*XLEN-1:0] step_acc_s, step_opd_s;
  logic [XLEN-1:0]   step_mplr_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_s;
  logic              finish_s;

  assign is_div_s   = FUNC3[2];
  assign a_signed_s = (FUNC3 == F3_MULH) || (FUNC3 == F3_MULHSU) ||
                      (FUNC3 == F3_DIV)  || (FUNC3 == F3_REM);
  assign b_signed_s = (FUNC3 == F3_MULH) || (FUNC3 == F3_DIV) || (FUNC3 == F3_REM);
  assign a_neg_s    = a_signed_s & OP_A[XLEN-1];
  assign b_neg_s    = b_signed_s & OP_B[XLEN-1];
  assign a_mag_s    = a_neg_s ? -OP_A : OP_A;
  assign b_mag_s    = b_neg_s ? -OP_B : OP_B;

  assign div_zero_s = (OP_B == '0);
  assign ovf_s      = a_signed_s && (OP_A == X_MIN) && (OP_B == '1);
  assign special_s  = is_div_s && (div_zero_s || ovf_s);

  // FUNC3[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    if (div_zero_s) begin
      special_res_s = FUNC3[1] ? OP_A : '1;
    end else begin
      special_res_s = FUNC3[1] ? '0 : X_MIN;
    end
  end

  rv_mdu_step #(
    .XLEN (XLEN),
    .BPC  (BITS_PER_CYCLE)
  ) u_step (
    .div_i  (func_q[2]),
    .acc_i  (acc_q),
    .opd_i  (opd_q),
    .mplr_i (mplr_q),
    .acc_o  (step_acc_s),
    .opd_o  (step_opd_s),
    .mplr_o (step_mplr_s)
  );

  assign prod_s = neg_q ? -step_acc_s : step_acc_s;
  assign quo_s  = step_acc_s[XLEN-1:0];
  assign rem_s  = step_acc_s[2*XLEN-1:XLEN];

  // Sign fix-up and result selection from the final iteration's outputs
  always_comb begin
    case (func_q)
      F3_MUL:                        final_s = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  final_s = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               final_s = neg_q ? -quo_s : quo_s;
      F3_REM, F3_REMU:               final_s = neg_q ? -rem_s : rem_s;
      default:                       final_s = '0;
    endcase
  end

`ifdef RV_MDU_EARLY_OUT_EN
  assign finish_s = (cnt_q == LAST) || (!func_q[2] && (step_mplr_s == '0));
`else
  assign finish_s = (cnt_q == LAST);
`endif

  // FSM and datapath next-state; FLUSH outranks START
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opd_d    = opd_q;
    mplr_d   = mplr_q;
    func_d   = func_q;
    neg_d    = neg_q;
    rd_tag_d = rd_tag_q;
    result_d = result_q;
    rd_d     = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (START && !FLUSH) begin
          func_d   = FUNC3;
          rd_tag_d = RD_IN;
          cnt_d    = '0;
          neg_d    = (is_div_s && FUNC3[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
          if (special_s) begin
            state_d  = ST_DONE;
            result_d = special_res_s;
            rd_d     = RD_IN;
          end else if (is_div_s) begin
            state_d = ST_CALC;
            acc_d   = {{XLEN{1'b0}}, a_mag_s};
            opd_d   = {{XLEN{1'b0}}, b_mag_s};
            mplr_d  = '0;
          end else begin
            state_d = ST_CALC;
            acc_d   = '0;
            opd_d   = {{XLEN{1'b0}}, a_mag_s};
            mplr_d  = b_mag_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (FLUSH) begin
          state_d = ST_IDLE;
        end else begin
          acc_d  = step_acc_s;
          opd_d  = step_opd_s;
          mplr_d = step_mplr_s;
          cnt_d  = cnt_q + CW'(1'b1);
          if (finish_s) begin
            state_d  = ST_DONE;
            result_d = final_s;
            rd_d     = rd_tag_q;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opd_q    <= '0;
      mplr_q   <= '0;
      func_q   <= 3'b000;
      neg_q    <= 1'b0;
      rd_tag_q <= 5'd0;
      result_q <= '0;
      rd_q     <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      mplr_q   <= mplr_d;
      func_q   <= func_d;
      neg_q    <= neg_d;
      rd_tag_q <= rd_tag_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;
  assign RD_OUT = rd_q;

endmodule
